// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;

    // Ceiling log2, used to size the iteration counter.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // True when DIGITS decimal digits can hold every DATA_WIDTH-bit value.
    function automatic logic digits_fit(input int unsigned data_w, input int unsigned digits);
        longint unsigned pow10;
        pow10 = 1;
        if (digits >= 10) begin
            return 1'b1;
        end
        for (int unsigned i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        return pow10 > ((64'd1 << data_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted_c
);

    assign adjusted_c = (digit >= BCD_DIGIT_W'(5)) ? digit + BCD_DIGIT_W'(3) : digit;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake
// and a leading-zero significance mask for display blanking.
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DIGITS     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         data,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]             nz_mask
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = clog2(DATA_WIDTH + 1);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
        $error("binary_to_bcd_seq: DATA_WIDTH must be in 1..32");
    end
    if (!digits_fit(DATA_WIDTH, DIGITS)) begin : g_bad_digits
        $error("binary_to_bcd_seq: DIGITS too small for DATA_WIDTH");
    end

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift_bin, shift_bin_next;
    logic [BCD_W-1:0]      scratch, scratch_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  busy_next, done_next;
    logic [BCD_W-1:0]      bcd_next;
    logic [DIGITS-1:0]     nz_mask_next;

    logic [BCD_W-1:0]      adjusted;
    logic [BCD_W-1:0]      scratch_iter;
    logic [DATA_WIDTH-1:0] bin_iter;
    logic [DIGITS-1:0]     digit_nz;
    logic [DIGITS-1:0]     mask_iter;

    // One iteration: adjust every digit, then shift the combined register left.
    assign scratch_iter = {adjusted[BCD_W-2:0], shift_bin[DATA_WIDTH-1]};
    assign bin_iter     = shift_bin << 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adjust u_adjust (
            .digit      (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted_c (adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );

        assign digit_nz[g] = |scratch_iter[g*BCD_DIGIT_W +: BCD_DIGIT_W];

        // Digit g is significant if it or any higher digit is nonzero; ones always shown.
        if (g == 0) begin : g_ones
            assign mask_iter[g] = 1'b1;
        end else begin : g_upper
            assign mask_iter[g] = |digit_nz[DIGITS-1:g];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_bin <= '0;
            scratch   <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            nz_mask   <= DIGITS'(1);
        end else begin
            state     <= state_next;
            shift_bin <= shift_bin_next;
            scratch   <= scratch_next;
            cnt       <= cnt_next;
            busy      <= busy_next;
            done      <= done_next;
            bcd       <= bcd_next;
            nz_mask   <= nz_mask_next;
        end
    end

    always_comb begin
        state_next     = state;
        shift_bin_next = shift_bin;
        scratch_next   = scratch;
        cnt_next       = cnt;
        busy_next      = busy;
        done_next      = 1'b0;
        bcd_next       = bcd;
        nz_mask_next   = nz_mask;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    shift_bin_next = data;
                    scratch_next   = '0;
                    cnt_next       = CNT_W'(DATA_WIDTH);
                    busy_next      = 1'b1;
                    state_next     = SHIFT;
                end
            end
            SHIFT: begin
                shift_bin_next = bin_iter;
                scratch_next   = scratch_iter;
                cnt_next       = cnt - CNT_W'(1);
                // Last iteration publishes straight from the iteration result.
                if (cnt == CNT_W'(1)) begin
                    bcd_next     = scratch_iter;
                    nz_mask_next = mask_iter;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/binary_to_bcd_seq.md
Name: binary_to_bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method.
- Fixed latency of DATA_WIDTH cycles, independent of the input value.
- Adds a start/busy/done handshake and a leading-zero significance mask so display drivers can blank unused digits.
- Sits between numeric producers (BPM counters, measurement registers) and seven-segment or hex display logic.

Parameters:
- DATA_WIDTH, 10, width of the binary input in bits, range 1 to 32.
- DIGITS, 4, number of BCD output digits. Elaboration must fail unless 10^DIGITS > 2^DATA_WIDTH - 1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only when busy=0.
- data  in  DATA_WIDTH  unsigned binary value; captured on the edge that accepts start.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: bcd and nz_mask just updated.
- bcd  out  4*DIGITS  result; digit i occupies bits [4i+3:4i]; digit 0 is the ones digit.
- nz_mask  out  DIGITS  bit i=1 if digit i is significant.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, bcd=0, nz_mask=1 (ones digit only), internal shift and count registers cleared. Reset takes priority over every other event.
- States:
  - IDLE: busy=0.
    - On an edge with start=1: load shift_bin<=data, clear the BCD scratch register, set cnt<=DATA_WIDTH, go to SHIFT, busy<=1.
  - SHIFT: busy=1. Each edge performs one iteration:
    - Every scratch digit >=5 gets +3.
    - Then {scratch, shift_bin} shifts left by 1, with the MSB of shift_bin entering scratch bit 0.
    - cnt decrements.
    - On the edge where cnt==1, the iteration result is written directly to bcd, nz_mask is updated, done<=1, busy<=0, and the state goes to IDLE.
- Latency: label the start-sampling edge as E0. Iterations occur on E1..E_DATA_WIDTH. done is high for exactly the cycle after edge E_DATA_WIDTH.
- Throughput: start is accepted in the same cycle done is high (busy=0). Back-to-back conversions therefore run every DATA_WIDTH+1 cycles with no bubble beyond that.
- start while busy=1: ignored; no queueing.
- data changes after acceptance: no effect.
- bcd and nz_mask hold the previous result throughout a conversion and change only on the done edge.
- done is never high for more than one cycle.
- Digit adjust:
  - Per-digit 4-bit add with no carry between digits.
  - Input digits are always <=9 by construction, so no digit exceeds 4 bits.
- nz_mask rules:
  - Bit 0 is always 1.
  - For i>0, bit i=1 iff some digit j>=i is nonzero.
  - Computed combinationally from the final result and registered with bcd.
- Reset mid-conversion: the conversion is aborted and all outputs return to reset values. No done pulse is generated.
- Value 0: the state machine runs the full DATA_WIDTH iterations (no early exit). Result is bcd=0, nz_mask=1.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_DIGIT_W=4.
  - State encoding IDLE/SHIFT (2-bit localparams).
  - A clog2 function used to size cnt.
- Sub-module bcd_digit_adjust: combinational, 4-bit in, 4-bit out (+3 if >=5). Instantiated DIGITS times with a generate loop.

Test Plan:
- Defaults (DATA_WIDTH=10, DIGITS=4): start with data=999 → done high after the 10th edge following the sampling edge. bcd=16'h0999, nz_mask=4'b0111, busy high for exactly 10 cycles.
- Defaults: data=0 → bcd=16'h0000, nz_mask=4'b0001. data=1023 → bcd=16'h1023, nz_mask=4'b1111. data=10 → bcd=16'h0010, nz_mask=4'b0011.
- Start with data=512; in mid-conversion pulse start with data=7 and change data → the second start is ignored. Result is bcd=16'h0512 with a single done pulse.
- Assert reset at cycle 5 of a conversion of 999 → next cycle busy=0, bcd=0, nz_mask=1. No done pulse follows; a subsequent start with 42 yields 16'h0042.
- Hold start=1 continuously with data stepping 100,101,102 at each accept → done pulses every 11 cycles. Results are 0100, 0101, 0102 in order.
- DATA_WIDTH=16, DIGITS=5: data=65535 → bcd=20'h65535 after 16 iterations. Random sweep of 1000 values checked against a reference model.
